// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Owner encodings, default starvation limit and statistics counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam int DEF_MAX_WAIT = 3;
    localparam int STAT_W       = 32;

    // Stores return nothing, so only fetch grants and load grants claim the return path.
    function automatic owner_t owner_next(input logic f_gnt, input logic d_gnt, input logic d_we);
        owner_t v_own;
        if (f_gnt) begin
            v_own = OWN_FETCH;
        end else if (d_gnt && !d_we) begin
            v_own = OWN_DATA;
        end else begin
            v_own = OWN_NONE;
        end
        return v_own;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been denied.
// o_sat flags that the count has reached MAX_WAIT.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = (r_cnt == CNT_W'(MAX_WAIT));
    assign o_sat = w_sat;

    // Counter register: clear wins over increment, increment stops at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and data load/store.
// Optional MEM_ARB_STATS_EN adds conflict/starvation/busy counters as extra outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              f_stall,
    output logic              d_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_conflict,
    output logic [STAT_W-1:0] stat_starve_win,
    output logic [STAT_W-1:0] stat_busy
`endif
);

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic        w_f_gnt;
    logic        w_d_gnt;
    logic        w_sat;
    logic        w_starve_inc;
    logic        w_starve_clr;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;

    arb_starve_ctr #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_starve_inc),
        .i_clr (w_starve_clr),
        .o_sat (w_sat)
    );

    // Grant selection and next owner: data has priority until fetch has waited MAX_WAIT cycles.
    always_comb begin
        w_f_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        if (reset) begin
            w_f_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end else if (f_req && d_req) begin
            if (w_sat) begin
                w_f_gnt = 1'b1;
            end else begin
                w_d_gnt = 1'b1;
            end
        end else if (d_req) begin
            w_d_gnt = 1'b1;
        end else if (f_req) begin
            w_f_gnt = 1'b1;
        end else begin
            w_f_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end
        w_owner_nxt = owner_next(w_f_gnt, w_d_gnt, d_we);
    end

    assign w_starve_inc = f_req & w_d_gnt;
    assign w_starve_clr = w_f_gnt | ~f_req;

    // Owner state register; async reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Read-data holding registers capture the RAM word in the owner's return cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            if (r_owner == OWN_FETCH) begin
                r_f_rdata <= mem_rdata;
            end else begin
                r_f_rdata <= r_f_rdata;
            end
            if (r_owner == OWN_DATA) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

    // Output drive: RAM request from the granted port, return data bypassed in its valid cycle.
    always_comb begin
        f_gnt     = w_f_gnt;
        d_gnt     = w_d_gnt;
        f_stall   = f_req & ~w_f_gnt;
        d_stall   = d_req & ~w_d_gnt;
        mem_en    = w_f_gnt | w_d_gnt;
        mem_wdata = d_wdata;
        if (w_d_gnt) begin
            mem_addr = d_addr;
        end else begin
            mem_addr = f_addr;
        end
        if (w_d_gnt && d_we) begin
            mem_wmask = d_wmask;
        end else begin
            mem_wmask = 4'b0000;
        end
        f_rvalid = (r_owner == OWN_FETCH);
        d_rvalid = (r_owner == OWN_DATA);
        if (r_owner == OWN_FETCH) begin
            f_rdata = mem_rdata;
        end else begin
            f_rdata = r_f_rdata;
        end
        if (r_owner == OWN_DATA) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = r_d_rdata;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_conflict_cnt;
    logic [STAT_W-1:0] r_starve_win_cnt;
    logic [STAT_W-1:0] r_busy_cnt;

    // Free-running wrap-around activity counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_cnt   <= {STAT_W{1'b0}};
            r_starve_win_cnt <= {STAT_W{1'b0}};
            r_busy_cnt       <= {STAT_W{1'b0}};
        end else begin
            if (f_req && d_req) begin
                r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
            end else begin
                r_conflict_cnt <= r_conflict_cnt;
            end
            if (w_f_gnt && d_req && w_sat) begin
                r_starve_win_cnt <= r_starve_win_cnt + STAT_W'(1);
            end else begin
                r_starve_win_cnt <= r_starve_win_cnt;
            end
            if (w_f_gnt || w_d_gnt) begin
                r_busy_cnt <= r_busy_cnt + STAT_W'(1);
            end else begin
                r_busy_cnt <= r_busy_cnt;
            end
        end
    end

    assign stat_conflict   = r_conflict_cnt;
    assign stat_starve_win = r_starve_win_cnt;
    assign stat_busy       = r_busy_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected read data, a monitor checks returns.
// Statistics outputs are checked when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [22:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [22:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        f_stall;
    logic        d_stall;
    logic        mem_en;
    logic [22:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_conflict;
    logic [31:0] stat_starve_win;
    logic [31:0] stat_busy;
    logic [31:0] snap_conflict;
    logic [31:0] snap_starve;
    logic [31:0] snap_busy;
`endif

    int checks;
    int failures;
    logic [31:0] fq[$];
    logic [31:0] dq[$];
    logic [31:0] mem_arr [0:63];

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wmask   (d_wmask),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .f_stall   (f_stall),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_conflict   (stat_conflict),
        .stat_starve_win (stat_starve_win),
        .stat_busy       (stat_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: byte-masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wmask != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem_arr[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem_arr[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Return-path monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (f_rvalid === 1'b1) begin
            if (fq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL f_rvalid_unexpected: got rvalid with data %h expected none", f_rdata);
            end else begin
                chk("f_rdata", f_rdata, fq.pop_front());
            end
        end
        if (d_rvalid === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d_rvalid_unexpected: got rvalid with data %h expected none", d_rdata);
            end else begin
                chk("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    task automatic drive(input logic fr, input logic [22:0] fa, input logic dr, input logic dwe,
                         input logic [22:0] da, input logic [3:0] dm, input logic [31:0] dwd);
        f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wmask = dm; d_wdata = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 23'd0, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
    endtask

    task automatic expect_cyc(input string tag, input logic efg, input logic edg,
                              input logic [22:0] eaddr, input logic [3:0] ewm, input logic [31:0] ewd);
        @(negedge clk);
        chk({tag, ".f_gnt"}, {31'd0, f_gnt}, {31'd0, efg});
        chk({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, edg});
        chk({tag, ".f_stall"}, {31'd0, f_stall}, {31'd0, f_req & ~efg});
        chk({tag, ".d_stall"}, {31'd0, d_stall}, {31'd0, d_req & ~edg});
        chk({tag, ".mem_en"}, {31'd0, mem_en}, {31'd0, efg | edg});
        chk({tag, ".mem_wmask"}, {28'd0, mem_wmask}, {28'd0, ewm});
        if (efg || edg) chk({tag, ".mem_addr"}, {9'd0, mem_addr}, {9'd0, eaddr});
        if (ewm != 4'b0000) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mem_rdata = 32'd0;
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'd0;
        mem_arr[4]  = 32'hDEADBEEF;
        mem_arr[5]  = 32'h0BADF00D;
        mem_arr[8]  = 32'h11223344;
        mem_arr[16] = 32'hCAFEF00D;

        // Reset with both requests asserted: everything must stay quiet.
        reset = 1'b1;
        drive(1'b1, 23'h10, 1'b1, 1'b1, 23'h40, 4'b1111, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rst.f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst.d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst.mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst.mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst.f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst.f_rdata", f_rdata, 32'd0);
        chk("rst.d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        expect_cyc("idle0", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);

        // Fetch only.
        drive(1'b1, 23'h10, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        fq.push_back(32'hDEADBEEF);
        expect_cyc("fetch", 1'b1, 1'b0, 23'h10, 4'b0000, 32'd0);
        idle();
        expect_cyc("fetch_ret", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);

        // Load colliding with fetch: data wins, fetch data register untouched.
        drive(1'b1, 23'h10, 1'b1, 1'b0, 23'h40, 4'b0000, 32'd0);
        dq.push_back(32'hCAFEF00D);
        expect_cyc("coll", 1'b0, 1'b1, 23'h40, 4'b0000, 32'd0);
        idle();
        @(negedge clk);
        chk("coll.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("coll.f_rdata_hold", f_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Byte store, then no return, then read the merged word back.
        drive(1'b0, 23'd0, 1'b1, 1'b1, 23'h22, 4'b0100, 32'h00AB0000);
        expect_cyc("store", 1'b0, 1'b1, 23'h22, 4'b0100, 32'h00AB0000);
        idle();
        @(negedge clk);
        chk("store.no_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 23'd0, 1'b1, 1'b0, 23'h20, 4'b0000, 32'd0);
        dq.push_back(32'h11AB3344);
        expect_cyc("load_back", 1'b0, 1'b1, 23'h20, 4'b0000, 32'd0);

        // Starvation: three data wins, forced fetch win, then data again.
`ifdef MEM_ARB_STATS_EN
        snap_conflict = stat_conflict;
        snap_starve   = stat_starve_win;
        snap_busy     = stat_busy;
`endif
        drive(1'b1, 23'h10, 1'b1, 1'b0, 23'h40, 4'b0000, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                fq.push_back(32'hDEADBEEF);
                expect_cyc($sformatf("starve%0d", i), 1'b1, 1'b0, 23'h10, 4'b0000, 32'd0);
            end else begin
                dq.push_back(32'hCAFEF00D);
                expect_cyc($sformatf("starve%0d", i), 1'b0, 1'b1, 23'h40, 4'b0000, 32'd0);
            end
        end
        idle();
        expect_cyc("starve_ret", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
`ifdef MEM_ARB_STATS_EN
        chk("stat_conflict", stat_conflict - snap_conflict, 32'd5);
        chk("stat_starve_win", stat_starve_win - snap_starve, 32'd1);
        chk("stat_busy", stat_busy - snap_busy, 32'd5);
`endif

        // Back-to-back fetches at different addresses.
        drive(1'b1, 23'h10, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        fq.push_back(32'hDEADBEEF);
        expect_cyc("b2b0", 1'b1, 1'b0, 23'h10, 4'b0000, 32'd0);
        drive(1'b1, 23'h14, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        fq.push_back(32'h0BADF00D);
        expect_cyc("b2b1", 1'b1, 1'b0, 23'h14, 4'b0000, 32'd0);
        idle();
        expect_cyc("b2b_ret", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);

        // Reset pulse while a fetch is in flight: no return afterwards.
        drive(1'b1, 23'h10, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        @(negedge clk);
        chk("rmid.f_gnt", {31'd0, f_gnt}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid.f_gnt_rst", {31'd0, f_gnt}, 32'd0);
        chk("rmid.mem_en_rst", {31'd0, mem_en}, 32'd0);
        chk("rmid.f_rvalid_rst", {31'd0, f_rvalid}, 32'd0);
        chk("rmid.f_rdata_rst", f_rdata, 32'd0);
        chk("rmid.d_rdata_rst", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rmid.no_rvalid", {31'd0, f_rvalid}, 32'd0);
        @(posedge clk);
        #1;

        // Recovery fetch.
        drive(1'b1, 23'h14, 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        fq.push_back(32'h0BADF00D);
        expect_cyc("recover", 1'b1, 1'b0, 23'h14, 4'b0000, 32'd0);
        idle();
        expect_cyc("recover_ret", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);
        expect_cyc("drain", 1'b0, 1'b0, 23'd0, 4'b0000, 32'd0);

        chk("fq_empty", fq.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
